qadd_acc: RTL and testbench



---
 rtl/qadd_acc.sv | 130 +++++++++++++
 tb/tb_qadd_acc.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/qadd_acc.sv
// Streaming sign-magnitude fixed-point frame accumulator with magnitude saturation
// and a valid/ready result hand-off.
`timescale 1ns/1ps
module qadd_acc #(
    parameter int Q     = 19,
    parameter int N     = 32,
    parameter int LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N-1:0]     i_data,
    input  logic             i_sub,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [N-1:0]     o_sum,
    output logic             o_ovf
);
    // state  | meaning
    // IDLE   | waiting for the first sample of a frame
    // ACCUM  | frame in progress, counting samples
    // DONE   | result held until downstream takes it
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    if (Q >= N - 1) begin : g_q_range
        $error("qadd_acc: Q must leave at least one integer magnitude bit");
    end

    state_t           state;
    logic             acc_sign;
    logic [N-2:0]     acc_mag;
    logic             ovf;
    logic [LEN_W:0]   cnt;
    logic [LEN_W:0]   len_q;

    logic             smp_sign;
    logic [N-2:0]     smp_mag;
    logic             base_sign;
    logic [N-2:0]     base_mag;
    logic [N-1:0]     mag_sum;
    logic             res_sign;
    logic [N-2:0]     res_mag;
    logic             res_ovf;
    logic [LEN_W:0]   len_eff;
    logic [LEN_W:0]   cnt_nxt;

    // A zero frame length maps onto the extra counter bit, i.e. 2^LEN_W samples.
    assign len_eff = {(i_len == '0), i_len};
    assign cnt_nxt = cnt + (LEN_W+1)'(1);

    always_comb begin
        smp_mag   = i_data[N-2:0];
        smp_sign  = (i_data[N-1] ^ i_sub) & (|smp_mag);
        base_sign = (state == S_IDLE) ? 1'b0 : acc_sign;
        base_mag  = (state == S_IDLE) ? '0 : acc_mag;
        mag_sum   = {1'b0, base_mag} + {1'b0, smp_mag};
        res_sign  = base_sign;
        res_mag   = mag_sum[N-2:0];
        res_ovf   = 1'b0;
        if (base_sign == smp_sign) begin
            if (mag_sum[N-1]) begin
                res_mag = '1;
                res_ovf = 1'b1;
            end
        end else if (base_mag >= smp_mag) begin
            res_mag = base_mag - smp_mag;
        end else begin
            res_sign = smp_sign;
            res_mag  = smp_mag - base_mag;
        end
        if (res_mag == '0) begin
            res_sign = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_IDLE;
            acc_sign <= 1'b0;
            acc_mag  <= '0;
            ovf      <= 1'b0;
            cnt      <= '0;
            len_q    <= '0;
        end else if (i_clear) begin
            state    <= S_IDLE;
            acc_sign <= 1'b0;
            acc_mag  <= '0;
            ovf      <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        acc_sign <= res_sign;
                        acc_mag  <= res_mag;
                        ovf      <= res_ovf;
                        cnt      <= (LEN_W+1)'(1);
                        len_q    <= len_eff;
                        state    <= (len_eff == (LEN_W+1)'(1)) ? S_DONE : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (i_valid) begin
                        acc_sign <= res_sign;
                        acc_mag  <= res_mag;
                        ovf      <= ovf | res_ovf;
                        cnt      <= cnt_nxt;
                        if (cnt_nxt == len_q) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_ready = (state != S_DONE);
    assign o_valid = (state == S_DONE);
    assign o_sum   = {acc_sign, acc_mag};
    assign o_ovf   = ovf;
endmodule

// File: tb/tb_qadd_acc.sv
// Directed-vector bench for qadd_acc with immediate-assertion checks.
`timescale 1ns/1ps
module tb_qadd_acc;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_clear;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    logic        i_sub;
    logic [7:0]  i_len;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_sum;
    logic        o_ovf;

    int vec_cnt = 0;
    int err_cnt = 0;

    qadd_acc #(.Q(19), .N(32), .LEN_W(8)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (i_clear),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_sub   (i_sub),
        .i_len   (i_len),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_ovf   (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic [7:0] l);
        i_valid = 1'b1;
        i_data  = d;
        i_sub   = s;
        i_len   = l;
        step();
        i_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        i_ready = 1'b1;
        step();
        chk(tag, 32'(o_valid), 32'd0);
        i_ready = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_clear = 1'b0; i_valid = 1'b0; i_data = '0;
        i_sub = 1'b0; i_len = '0; i_ready = 1'b0;
        step(); step();
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_sum",   o_sum,        32'd0);
        chk("rst_ovf",   32'(o_ovf),   32'd0);
        i_rst = 1'b0;
        step();

        // 1.0 + 2.0 - 0.5; later i_len values must be ignored
        send(32'h0008_0000, 1'b0, 8'd3);
        send(32'h0010_0000, 1'b0, 8'd7);
        chk("basic_not_yet", 32'(o_valid), 32'd0);
        send(32'h8004_0000, 1'b0, 8'd7);
        chk("basic_valid", 32'(o_valid), 32'd1);
        chk("basic_ready", 32'(o_ready), 32'd0);
        chk("basic_sum",   o_sum,        32'h0014_0000);
        chk("basic_ovf",   32'(o_ovf),   32'd0);
        drain("basic_drain");

        send(32'h0008_0000, 1'b0, 8'd2);
        send(32'h8008_0000, 1'b0, 8'd2);
        chk("cancel_sum", o_sum,      32'h0000_0000);
        chk("cancel_ovf", 32'(o_ovf), 32'd0);
        drain("cancel_drain");

        send(32'h0008_0000, 1'b0, 8'd2);
        send(32'h8018_0000, 1'b0, 8'd2);
        chk("neg_sum", o_sum, 32'h8010_0000);
        drain("neg_drain");

        send(32'h7FFF_FFFF, 1'b0, 8'd2);
        send(32'h0000_0001, 1'b0, 8'd2);
        chk("satp_sum", o_sum,      32'h7FFF_FFFF);
        chk("satp_ovf", 32'(o_ovf), 32'd1);
        drain("satp_drain");

        send(32'hFFFF_FFFF, 1'b0, 8'd2);
        send(32'h8000_0001, 1'b0, 8'd2);
        chk("satn_sum", o_sum,      32'hFFFF_FFFF);
        chk("satn_ovf", 32'(o_ovf), 32'd1);
        drain("satn_drain");

        send(32'h0008_0000, 1'b0, 8'd1);
        chk("len1_valid", 32'(o_valid), 32'd1);
        chk("len1_sum",   o_sum,        32'h0008_0000);
        chk("len1_ovf",   32'(o_ovf),   32'd0);
        drain("len1_drain");

        // saturated value stays an operand: max - 1 = max-1, ovf sticky
        send(32'h7FFF_FFFF, 1'b0, 8'd3);
        send(32'h0000_0005, 1'b0, 8'd3);
        send(32'h8000_0001, 1'b0, 8'd3);
        chk("sticky_sum", o_sum,      32'h7FFF_FFFE);
        chk("sticky_ovf", 32'(o_ovf), 32'd1);
        drain("sticky_drain");

        send(32'h0008_0000, 1'b1, 8'd2);
        send(32'h8018_0000, 1'b1, 8'd2);
        chk("sub_sum", o_sum, 32'h0010_0000);
        drain("sub_drain");

        // negative zero, both plain and subtracted, must read +0
        send(32'h8000_0000, 1'b0, 8'd2);
        send(32'h8000_0000, 1'b1, 8'd2);
        chk("negzero_sum", o_sum, 32'h0000_0000);
        drain("negzero_drain");

        // backpressure: held sample must not be taken while DONE
        send(32'h0008_0000, 1'b0, 8'd1);
        i_valid = 1'b1; i_data = 32'h0020_0000; i_sub = 1'b0; i_len = 8'd1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_sum",   o_sum,        32'h0008_0000);
            chk("bp_ready", 32'(o_ready), 32'd0);
            chk("bp_valid", 32'(o_valid), 32'd1);
        end
        i_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(o_valid), 32'd0);
        chk("bp_release_sum",   o_sum,        32'h0008_0000);
        i_ready = 1'b0;
        step();
        i_valid = 1'b0;
        chk("bp_held_valid", 32'(o_valid), 32'd1);
        chk("bp_held_sum",   o_sum,        32'h0020_0000);
        drain("bp_drain");

        // length 0 means 256 samples
        for (int k = 0; k < 255; k++) send(32'h0000_0001, 1'b0, 8'd0);
        chk("len0_not_yet", 32'(o_valid), 32'd0);
        send(32'h0000_0001, 1'b0, 8'd0);
        chk("len0_valid", 32'(o_valid), 32'd1);
        chk("len0_sum",   o_sum,        32'h0000_0100);
        drain("len0_drain");

        // clear after 2 of 4 samples, with a sample presented that must be dropped
        send(32'h0008_0000, 1'b0, 8'd4);
        send(32'h0008_0000, 1'b0, 8'd4);
        i_clear = 1'b1; i_valid = 1'b1; i_data = 32'h0040_0000;
        step();
        i_clear = 1'b0; i_valid = 1'b0;
        chk("clr_sum",   o_sum,        32'd0);
        chk("clr_ready", 32'(o_ready), 32'd1);
        chk("clr_valid", 32'(o_valid), 32'd0);
        send(32'h0008_0000, 1'b0, 8'd1);
        chk("clr_next_valid", 32'(o_valid), 32'd1);
        chk("clr_next_sum",   o_sum,        32'h0008_0000);
        drain("clr_next_drain");

        // clear and ready together in DONE
        send(32'h7FFF_FFFF, 1'b0, 8'd2);
        send(32'h0000_0001, 1'b0, 8'd2);
        i_clear = 1'b1; i_ready = 1'b1;
        step();
        i_clear = 1'b0; i_ready = 1'b0;
        chk("clrrdy_sum",   o_sum,        32'd0);
        chk("clrrdy_ovf",   32'(o_ovf),   32'd0);
        chk("clrrdy_valid", 32'(o_valid), 32'd0);

        // async reset mid-frame
        send(32'h0008_0000, 1'b0, 8'd4);
        send(32'h0008_0000, 1'b0, 8'd4);
        #2 i_rst = 1'b1;
        #1;
        chk("arst_mid_sum",   o_sum,        32'd0);
        chk("arst_mid_ready", 32'(o_ready), 32'd1);
        step();
        i_rst = 1'b0;

        // async reset in DONE with ovf set
        send(32'h7FFF_FFFF, 1'b0, 8'd2);
        send(32'h0000_0001, 1'b0, 8'd2);
        #2 i_rst = 1'b1;
        #1;
        chk("arst_done_valid", 32'(o_valid), 32'd0);
        chk("arst_done_ovf",   32'(o_ovf),   32'd0);
        chk("arst_done_sum",   o_sum,        32'd0);
        chk("arst_done_ready", 32'(o_ready), 32'd1);
        step();
        i_rst = 1'b0;
        send(32'h0008_0000, 1'b0, 8'd1);
        chk("arst_next_sum", o_sum, 32'h0008_0000);
        drain("arst_next_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
